// File: rtl/asteroids_pkg.sv
// Shared asteroids game types: BCD score encoding and score-keeper states.
// Types only; no logic, no latency, no flow control.
package asteroids;

   typedef logic [23:0] bcd_score_t;

   localparam int         SCORE_DIGITS = 6;
   localparam bcd_score_t SCORE_SAT    = 24'h999990;

   typedef enum logic [1:0] {SC_IDLE, SC_PLAYING, SC_OVER} score_state_t;

endpackage

// File: rtl/bcd_add6.sv
// Six-digit BCD adder with decimal carry between digits.
// Purely combinational: zero latency, no flow control.
module bcd_add6
   import asteroids::*;
(
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic [23:0] sum,
   output logic        cout
);

   logic [4:0] dsum;
   logic       carry;

   always_comb begin
      sum   = '0;
      dsum  = '0;
      carry = 1'b0;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         dsum  = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0, carry};
         carry = (dsum > 5'd9);
         // +6 skips the six unused nibble codes so the low 4 bits are the decimal digit
         if (carry) dsum = dsum + 5'd6;
         sum[4*d +: 4] = dsum[3:0];
      end
      cout = carry;
   end

endmodule

// File: rtl/score_keeper.sv
// Captures per-frame BCD asteroid points and accumulates them one source per cycle into the score.
// Frame result settles N_SRC+2 cycles after vsync; a capture that arrives while busy is dropped and flagged.
module score_keeper
   import asteroids::*;
#(
   parameter int N_SRC      = 2,
   parameter int LIVES_INIT = 3,
   parameter int LIVES_MAX  = 7
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   vsync,
   input  logic                   game_begin,
   input  logic                   ship_hit,
   input  logic [N_SRC-1:0][10:0] ast_points,
   output logic [23:0]            score,
   output logic [23:0]            high_score,
   output logic [2:0]             lives,
   output logic                   extra_life,
   output logic                   game_over,
   output logic                   busy,
   output logic                   overrun
);

   localparam int               IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);
   localparam logic [2:0]       L_INIT   = 3'(LIVES_INIT);
   localparam logic [2:0]       L_MAX    = 3'(LIVES_MAX);

   score_state_t     state, state_nxt;
   bcd_score_t       pend [N_SRC];
   logic [IDX_W-1:0] idx;
   logic             cap;
   bcd_score_t       add_sum;
   logic             add_cout;
   logic             playing, acc, award, award_ok, hit, hit_zero, enter_over;

   bcd_add6 u_add (
      .a    (score),
      .b    (pend[idx]),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_nxt = state;
      game_over = 1'b0;
      case (state)
         SC_IDLE:    if (game_begin) state_nxt = SC_PLAYING;
         SC_PLAYING: if (!game_begin && lives == 3'd0) state_nxt = SC_OVER;
         SC_OVER: begin
            game_over = 1'b1;
            if (game_begin) state_nxt = SC_PLAYING;
         end
         default:    state_nxt = SC_IDLE;
      endcase
   end

   // lives == 0 while still PLAYING is the single cycle before OVER; nothing is accepted then
   always_comb begin
      playing    = (state == SC_PLAYING) && (lives != 3'd0);
      acc        = playing && busy;
      award      = acc && !add_cout && (add_sum[23:16] != score[23:16]);
      award_ok   = award && (lives != L_MAX);
      hit        = playing && ship_hit;
      hit_zero   = hit && !award_ok && (lives == 3'd1);
      enter_over = (state == SC_PLAYING) && (state_nxt == SC_OVER);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= SC_IDLE;
         cap        <= 1'b0;
         idx        <= '0;
         busy       <= 1'b0;
         score      <= '0;
         high_score <= '0;
         lives      <= '0;
         extra_life <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < N_SRC; i++) pend[i] <= '0;
      end else begin
         state      <= state_nxt;
         cap        <= vsync;
         extra_life <= 1'b0;
         if (game_begin) begin
            cap     <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            score   <= '0;
            lives   <= L_INIT;
            overrun <= 1'b0;
            for (int i = 0; i < N_SRC; i++) pend[i] <= '0;
         end else begin
            if (enter_over && score > high_score) high_score <= score;
            if (playing && cap) begin
               if (busy) begin
                  overrun <= 1'b1;
               end else begin
                  for (int i = 0; i < N_SRC; i++)
                     pend[i] <= {13'b0, ast_points[i] & 11'h7F0};
                  idx  <= '0;
                  busy <= 1'b1;
               end
            end
            // the fatal hit abandons the frame, including the add of this very cycle
            if (hit_zero) begin
               busy  <= 1'b0;
               lives <= 3'd0;
            end else begin
               if (acc) begin
                  score <= add_cout ? SCORE_SAT : add_sum;
                  if (idx == IDX_LAST) busy <= 1'b0;
                  else                 idx  <= idx + 1'b1;
               end
               extra_life <= award_ok;
               if (award_ok && !hit)      lives <= lives + 3'd1;
               else if (hit && !award_ok) lives <= lives - 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal-arithmetic game model queues expected frame/game-over results,
// and a monitor compares them when busy falls or game_over rises.
module tb_score_keeper;

   localparam int N_SRC      = 4;
   localparam int LIVES_INIT = 3;
   localparam int LIVES_MAX  = 7;

   typedef logic [N_SRC-1:0][10:0] pts_bus_t;

   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic        vsync = 1'b0;
   logic        game_begin = 1'b0;
   logic        ship_hit = 1'b0;
   pts_bus_t    ast_points = '0;
   logic [23:0] score, high_score;
   logic [2:0]  lives;
   logic        extra_life, game_over, busy, overrun;

   score_keeper #(.N_SRC(N_SRC), .LIVES_INIT(LIVES_INIT), .LIVES_MAX(LIVES_MAX)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .vsync      (vsync),
      .game_begin (game_begin),
      .ship_hit   (ship_hit),
      .ast_points (ast_points),
      .score      (score),
      .high_score (high_score),
      .lives      (lives),
      .extra_life (extra_life),
      .game_over  (game_over),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int score; int lives; int xl; int busy_len; bit ovr; } frame_exp_t;
   typedef struct { int high; int score; } over_exp_t;

   frame_exp_t  frame_q [$];
   over_exp_t   over_q  [$];
   int          checks = 0, failures = 0;
   int          m_score = 0, m_lives = 0, m_xl = 0, m_high = 0;
   bit          m_ovr = 0;
   logic [10:0] pts [N_SRC];
   int          xl_seen = 0, blen = 0;
   bit          busy_d = 0, gov_d = 0;

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r = '0;
      int x = v;
      for (int d = 0; d < 6; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int pval(input logic [10:0] p);
      return 100 * int'(p[10:8]) + 10 * int'(p[7:4]);
   endfunction

   function automatic pts_bus_t garbage();
      pts_bus_t g;
      for (int k = 0; k < N_SRC; k++) g[k] = 11'($urandom);
      return g;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!resetN) begin
         busy_d = 0; gov_d = 0; blen = 0;
      end else begin
         frame_exp_t fe;
         over_exp_t  oe;
         if (extra_life) xl_seen++;
         if (busy) blen++;
         if (busy_d && !busy) begin
            if (frame_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL frame_event: busy fell with no expected frame (t=%0t)", $time);
            end else begin
               fe = frame_q.pop_front();
               check("frame_score",    score,   to_bcd(fe.score));
               check("frame_lives",    lives,   fe.lives);
               check("frame_xl_count", xl_seen, fe.xl);
               check("frame_busy_len", blen,    fe.busy_len);
               check("frame_overrun",  overrun, fe.ovr);
            end
            blen = 0;
         end
         if (game_over && !gov_d) begin
            if (over_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL over_event: game_over rose unexpectedly (t=%0t)", $time);
            end else begin
               oe = over_q.pop_front();
               check("over_high_score", high_score, to_bcd(oe.high));
               check("over_score",      score,      to_bcd(oe.score));
               check("over_lives",      lives,      0);
            end
         end
         busy_d = busy;
         gov_d  = game_over;
      end
   end

   // ---------------- model + stimulus ----------------
   task automatic game_lost();
      over_exp_t o;
      if (m_score > m_high) m_high = m_score;
      o.high = m_high; o.score = m_score;
      over_q.push_back(o);
   endtask

   task automatic set_pts(input logic [10:0] a, input logic [10:0] b,
                          input logic [10:0] c, input logic [10:0] d);
      pts[0] = a; pts[1] = b; pts[2] = c; pts[3] = d;
   endtask

   task automatic rand_pts();
      for (int k = 0; k < N_SRC; k++)
         pts[k] = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 9)), 4'b0};
   endtask

   task automatic do_begin();
      @(negedge clk); game_begin = 1;
      @(negedge clk); game_begin = 0;
      m_score = 0; m_lives = LIVES_INIT; m_ovr = 0;
      check("begin_score",     score,     to_bcd(m_score));
      check("begin_lives",     lives,     m_lives);
      check("begin_overrun",   overrun,   m_ovr);
      check("begin_game_over", game_over, 0);
   endtask

   task automatic hit_idle();
      @(negedge clk); ship_hit = 1;
      @(negedge clk); ship_hit = 0;
      m_lives--;
      if (m_lives == 0) game_lost();
      repeat (3) @(negedge clk);
   endtask

   // hit_src: source whose add cycle coincides with ship_hit (-1: none)
   task automatic run_frame(input int hit_src, input bit extra_vsync, input bit abort);
      frame_exp_t e;
      int nv, nadd;
      bit aw, aok, over;
      e.busy_len = N_SRC; over = 0;
      nadd = abort ? 1 : N_SRC;
      if (extra_vsync) m_ovr = 1;
      for (int k = 0; k < nadd; k++) begin
         nv = m_score + pval(pts[k]);
         aw = 0;
         if (nv > 999999) nv = 999990;
         else if (nv / 10000 != m_score / 10000) aw = 1;
         aok = aw && (m_lives < LIVES_MAX);
         if (k == hit_src && !aok) begin
            m_lives--;
            if (m_lives == 0) begin e.busy_len = k + 1; over = 1; break; end
         end else if (aok && k != hit_src) begin
            m_lives++;
         end
         if (aok) m_xl++;
         m_score = nv;
      end
      if (abort) begin
         m_score = 0; m_lives = LIVES_INIT; m_ovr = 0; e.busy_len = 2;
      end
      e.score = m_score; e.lives = m_lives; e.xl = m_xl; e.ovr = m_ovr;
      frame_q.push_back(e);
      if (over) game_lost();

      @(negedge clk); vsync = 1; ast_points = garbage();
      @(negedge clk); vsync = 0;
      for (int k = 0; k < N_SRC; k++) ast_points[k] = pts[k];
      for (int c = 0; c < N_SRC + 4; c++) begin
         @(negedge clk);
         ast_points = garbage();
         vsync      = extra_vsync && (c == 0);
         ship_hit   = (c == hit_src);
         game_begin = abort && (c == 1);
      end
      @(negedge clk); vsync = 0; ship_hit = 0; game_begin = 0;
   endtask

   task automatic idle_window(input string name);
      int cnt = 0;
      @(negedge clk); vsync = 1; ast_points = garbage();
      @(negedge clk); vsync = 0;
      repeat (N_SRC + 3) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check(name, cnt, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_score"},      score,      0);
      check({tag, "_high_score"}, high_score, 0);
      check({tag, "_lives"},      lives,      0);
      check({tag, "_extra_life"}, extra_life, 0);
      check({tag, "_game_over"},  game_over,  0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_overrun"},    overrun,    0);
   endtask

   initial begin
      #2 resetN = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetN = 1;
      @(negedge clk); ship_hit = 1;
      @(negedge clk); ship_hit = 0;
      check("idle_hit_lives", lives, m_lives);
      idle_window("idle_no_accumulate");

      // game 1: basic frame, 10000 crossing, crossing with coincident hit
      do_begin();
      set_pts(11'h020, 11'h050, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      check("first_frame_score", score, 24'h000070);
      set_pts(11'h790, 11'h790, 11'h790, 11'h790);
      repeat (3) run_frame(-1, 0, 0);
      set_pts(11'h430, 11'h000, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      check("pre_cross_score", score, 24'h009980);
      set_pts(11'h100, 11'h000, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      check("cross_score", score, 24'h010080);
      check("cross_lives", lives, 3'd4);
      hit_idle();
      set_pts(11'h790, 11'h790, 11'h790, 11'h790);
      repeat (3) run_frame(-1, 0, 0);
      set_pts(11'h500, 11'h000, 11'h000, 11'h000);
      run_frame(0, 0, 0);
      check("cross_hit_lives", lives, 3'd3);
      check("cross_hit_score", score, 24'h020060);

      // randomized play, including fatal mid-frame hits, overruns and restarts mid-frame
      for (int it = 0; it < 60; it++) begin
         int r, hs;
         if (m_lives == 0) do_begin();
         rand_pts();
         r = $urandom_range(0, 9);
         if (r == 0)      hit_idle();
         else if (r == 1) run_frame(-1, 0, 1);
         else begin
            hs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_SRC - 1)) : -1;
            run_frame(hs, (hs < 0) && ($urandom_range(0, 5) == 0), 0);
         end
      end

      // saturation game: lives cap at 7, then top out at 999990
      do_begin();
      set_pts(11'h790, 11'h790, 11'h790, 11'h790);
      while (m_score + 3160 <= 998560) run_frame(-1, 0, 0);
      set_pts(11'h790, 11'h600, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      check("near_sat_score", score, 24'h999950);
      set_pts(11'h100, 11'h000, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      check("sat_score", score, 24'h999990);
      check("sat_lives", lives, 3'd7);
      while (m_lives > 0) hit_idle();
      @(negedge clk); ship_hit = 1;
      @(negedge clk); ship_hit = 0;
      check("over_hit_lives", lives, m_lives);
      idle_window("over_no_accumulate");

      // a smaller score must leave the high score alone
      do_begin();
      set_pts(11'h050, 11'h000, 11'h000, 11'h000);
      run_frame(-1, 0, 0);
      while (m_lives > 0) hit_idle();

      // overrun, then restart clears it
      do_begin();
      rand_pts();
      run_frame(-1, 1, 0);
      check("overrun_flag", overrun, 1);
      do_begin();

      // asynchronous reset in the middle of a frame
      rand_pts();
      @(negedge clk); vsync = 1;
      @(negedge clk); vsync = 0;
      for (int k = 0; k < N_SRC; k++) ast_points[k] = pts[k];
      repeat (2) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 resetN = 0;
      #1 check_all_zero("midreset");
      repeat (2) @(negedge clk);
      resetN = 1;
      repeat (3) @(negedge clk);

      check("pending_frames", frame_q.size(), 0);
      check("pending_overs",  over_q.size(),  0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Receiving end of the per-frame asteroid points interface. It captures the BCD `ast_points` words that each asteroid group emits one cycle after `vsync` and accumulates them serially into a 6-digit BCD score. It also tracks lives, awards an extra life at every 10000-point boundary, keeps the high score, and drives `game_over` to the game controller and the score/lives overlay.

## Interface
Parameters:
- `N_SRC`, default 2: number of asteroid-group point sources.
- `LIVES_INIT`, default 3: lives at game start.
- `LIVES_MAX`, default 7: lives ceiling.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `resetN`  in  1: reset, asynchronous, active-low.
- `vsync`  in  1: 1-cycle frame pulse.
- `game_begin`  in  1: 1-cycle pulse that starts a new game.
- `ship_hit`  in  1: 1-cycle pulse when the ship is destroyed.
- `ast_points`  in  [N_SRC-1:0][10:0]: per-source BCD points. Bits 10:4 are the tens/hundreds digits; bits 3:0 are the units digit, always zero. Valid only in the cycle after `vsync`.
- `score`  out  24: 6-digit BCD score.
- `high_score`  out  24: 6-digit BCD high score.
- `lives`  out  3: remaining lives.
- `extra_life`  out  1: 1-cycle pulse when an extra life is awarded.
- `game_over`  out  1: level signal, high in the OVER state.
- `busy`  out  1: high while accumulation is in progress.
- `overrun`  out  1: sticky error flag; cleared by `game_begin`.

## Operation
- Reset values:
  - state = IDLE
  - `score` = 0, `high_score` = 0, `lives` = 0
  - `extra_life` = 0, `game_over` = 0, `busy` = 0, `overrun` = 0
- FSM:
  - IDLE→PLAYING on `game_begin`.
  - PLAYING→OVER when `lives` reaches 0.
  - OVER→PLAYING on `game_begin`.
- On `game_begin` (from any state): `score` = 0, `lives` = LIVES_INIT, `overrun` = 0, pending registers cleared.
- Capture:
  - In PLAYING, the cycle after `vsync` (a registered `vsync`, called `cap`) latches all `ast_points` into `pend[i]` = {13'b0, ast_points[i][10:4], 4'b0}.
  - The source index is cleared to 0 and `busy` is set.
- Accumulate (one source per cycle, index 0 upward):
  - `score` <= bcd_add(`score`, `pend[idx]`).
  - After index N_SRC-1, `busy` clears.
  - Zero-valued entries still take their cycle, so latency is fixed.
- BCD arithmetic:
  - Digit-wise add with decimal carry.
  - If the add carries out of digit 5, `score` saturates at 24'h999990.
- Extra life:
  - Awarded when an add changes `score[23:16]` (ten-thousands and above) and no saturation occurred.
  - Pulse `extra_life`, `lives`+1, unless `lives` == LIVES_MAX, in which case the award is dropped and no pulse is given.
- Ship hit: in PLAYING, `lives`-1.
  - If the result is 0: enter OVER. Any accumulation in flight is abandoned and `busy` clears.
  - In IDLE or OVER, `ship_hit` is ignored.
- High score: on entry to OVER, if `score` > `high_score` (unsigned compare, valid for BCD), then `high_score` <= `score`.
- Simultaneous `ship_hit` and an extra-life award in the same cycle: net `lives` change 0; `extra_life` still pulses.
- `game_begin` during `busy`: the game is restarted and in-flight adds are discarded.
- `cap` while `busy`: the capture is dropped, `overrun` is set, and accumulation continues undisturbed.
- Points are never accumulated outside PLAYING.

## Timing
- `vsync` at cycle T:
  - `cap` at T+1.
  - Adds at T+2 … T+1+N_SRC.
  - `busy` high T+2 … T+1+N_SRC, low at T+2+N_SRC.
- `score` is updated registered, one source per cycle. The final value is visible at T+2+N_SRC.
- `extra_life` is asserted in the cycle after the crossing add.
- `lives` decrements the cycle after `ship_hit`. `game_over` rises the cycle after `lives` becomes 0.
- `high_score` updates the same cycle `game_over` rises.
- `resetN` low forces all outputs to their reset values immediately. This includes mid-accumulation.

## Structure
- Add to the shared `asteroids` package:
  - `bcd_score_t` (logic [23:0])
  - `SCORE_DIGITS` = 6
  - enum `score_state_t` {SC_IDLE, SC_PLAYING, SC_OVER}
- One sub-module, `bcd_add6`: combinational, ports a[23:0], b[23:0] → sum[23:0], cout. It is reused by the overlay's digit logic.
- All state registers live in `score_keeper`: FSM, pend array, index counter, lives, score, high_score, overrun.

## Test plan
- Reset, `game_begin`, then `vsync` with ast_points = {11'h020, 11'h050} → `score` = 24'h000070 at T+4, `busy` high exactly 2 cycles.
- `score` = 24'h009980, points 11'h100 (100) → `score` = 24'h010080, one `extra_life` pulse, `lives` 3→4.
- `score` = 24'h999950, points 11'h100 → `score` = 24'h999990, no `extra_life`.
- `lives` = 1, `ship_hit` → `lives` = 0, `game_over` = 1. `high_score` takes `score` if greater, and keeps its value if `score` is smaller.
- `lives` = 7 with a boundary crossing → `lives` stays 7, no pulse. Boundary crossing with a same-cycle `ship_hit` at `lives` = 3 → `lives` stays 3, pulse present.
- `vsync` reissued during `busy` (N_SRC = 4) → `overrun` = 1 and the first frame's sum is intact. Then `game_begin` → `overrun` = 0, `score` = 0, `lives` = 3. Reset asserted mid-accumulation → all outputs 0.
